// File: rtl/mult_div_unit_if.sv
// Control, operand and result bundle between the E-stage decode logic and
// the multiply/divide unit. The master side issues operations and mthi/mtlo
// writes; the slave side (the unit) reports busy and the HI/LO contents.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  MDop;
    logic        MDsign;
    logic        immWrite;
    logic        HIWrite;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIRead;
    logic        busy;
    logic [31:0] HLOut;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDop, MDsign, immWrite, HIWrite, flush, A, B, HIRead,
        input  busy, HLOut, HI, LO
    );

    modport slave (
        input  start, MDop, MDsign, immWrite, HIWrite, flush, A, B, HIRead,
        output busy, HLOut, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit. The result is computed combinationally
// when an operation launches and parked in pending registers; a down-counter
// then models the fixed multi-cycle latency before HI/LO are updated.
// Divide by zero occupies the full divide latency but leaves HI/LO untouched.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_ok_q, pend_ok_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        launch_mul;
    logic        launch_div;
    logic        imm_ok;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // Product and sign-magnitude divide; the low 64 bits of the extended
    // product are the two's complement result for both signed and unsigned
    always_comb begin
        neg_a   = md.MDsign & md.A[31];
        neg_b   = md.MDsign & md.B[31];
        ext_a   = {{32{neg_a}}, md.A};
        ext_b   = {{32{neg_b}}, md.B};
        product = ext_a * ext_b;
        mag_a   = neg_a ? (~md.A + 32'd1) : md.A;
        mag_b   = neg_b ? (~md.B + 32'd1) : md.B;
        div_b   = (mag_b == '0) ? 32'd1 : mag_b;
        uq      = mag_a / div_b;
        ur      = mag_a % div_b;
        quot    = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem     = neg_a ? (~ur + 32'd1) : ur;
    end

    // Launch and mthi/mtlo qualification; flush kills both, start beats immWrite
    always_comb begin
        launch_mul = (state_q == IDLE) & md.start & ~md.flush & (md.MDop == 2'b01);
        launch_div = (state_q == IDLE) & md.start & ~md.flush & (md.MDop == 2'b10);
        imm_ok     = (state_q == IDLE) & ~md.start & md.immWrite & ~md.flush;
    end

    // Next-state, latency counter, pending result and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (launch_mul) begin
                    pend_hi_d = product[63:32];
                    pend_lo_d = product[31:0];
                    pend_ok_d = 1'b1;
                    cnt_d     = 4'(MULT_CYCLES);
                    state_d   = RUN;
                end else if (launch_div) begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    pend_ok_d = (md.B != '0);
                    cnt_d     = 4'(DIV_CYCLES);
                    state_d   = RUN;
                end else if (imm_ok) begin
                    if (md.HIWrite) begin
                        hi_d = md.A;
                    end else begin
                        lo_d = md.A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if ((cnt_q == 4'd1) || (cnt_q == 4'd0)) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md.busy  = (state_q == RUN);
    assign md.HLOut = md.HIRead ? hi_q : lo_q;
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit. Each launched operation pushes its
// expected HI/LO and busy length; a monitor pops and compares whenever busy
// falls. Expected values come from plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    bit   prev_busy = 1'b0;
    int   run_len = 0;

    mult_div_unit_if md_if ();

    mult_div_unit #(
        .MULT_CYCLES(MULT_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: count busy cycles and check the committed result when busy drops
    always @(negedge clk) begin
        exp_t e;
        if (md_if.busy === 1'b1) begin
            run_len++;
        end else begin
            if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("commit_hi", md_if.HI, e.hi);
                    checkOutput("commit_lo", md_if.LO, e.lo);
                    checkOutput("busy_len", run_len, e.len);
                end
            end
            run_len = 0;
        end
        prev_busy = (md_if.busy === 1'b1);
    end

    // Launch one operation (or no-op) and follow it until the unit is idle
    task automatic applyStimulus(input logic [1:0] op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit abort, input bit poke, input bit with_imm);
        exp_t        e;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] up;
        bit          real_op;
        real_op = (op == 2'b01) || (op == 2'b10);
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.len = 0;
        if (op == 2'b01) begin
            e.len = MULT_LAT;
            if (sgn) begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end else begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
        end else if (op == 2'b10) begin
            e.len = DIV_LAT;
            if (b != 32'd0) begin
                if (sgn) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        end
        if (abort) begin
            e.hi  = 32'd0;
            e.lo  = 32'd0;
            e.len = 3;
        end
        checkOutput("busy_at_start", md_if.busy, 32'd0);
        md_if.start  = 1'b1;
        md_if.MDop   = op;
        md_if.MDsign = sgn;
        md_if.A      = a;
        md_if.B      = b;
        if (with_imm) begin
            md_if.immWrite = 1'b1;
            md_if.HIWrite  = 1'b1;
        end
        if (real_op) sb_q.push_back(e);
        @(negedge clk);
        md_if.start    = 1'b0;
        md_if.MDop     = 2'b00;
        md_if.immWrite = 1'b0;
        if (!real_op) begin
            checkOutput("noop_busy", md_if.busy, 32'd0);
            checkOutput("noop_hi", md_if.HI, model_hi);
            checkOutput("noop_lo", md_if.LO, model_lo);
            return;
        end
        checkOutput("busy_first", md_if.busy, 32'd1);
        if (abort) begin
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            checkOutput("abort_busy", md_if.busy, 32'd0);
            checkOutput("abort_hi", md_if.HI, 32'd0);
            checkOutput("abort_lo", md_if.LO, 32'd0);
            model_hi = 32'd0;
            model_lo = 32'd0;
            repeat (MULT_LAT) @(negedge clk);
            checkOutput("abort_no_commit", md_if.HI, 32'd0);
            return;
        end
        if (poke) begin
            @(negedge clk);
            md_if.immWrite = 1'b1;
            md_if.HIWrite  = 1'b0;
            md_if.A        = 32'hA5A5_5A5A;
            @(negedge clk);
            md_if.immWrite = 1'b0;
        end
        for (int i = 0; i < 40 && md_if.busy === 1'b1; i++) @(negedge clk);
        checkOutput("busy_drop", md_if.busy, 32'd0);
        model_hi = e.hi;
        model_lo = e.lo;
        md_if.HIRead = 1'b1;
        #1 checkOutput("hlout_hi", md_if.HLOut, model_hi);
        md_if.HIRead = 1'b0;
        #1 checkOutput("hlout_lo", md_if.HLOut, model_lo);
    endtask

    // mthi/mtlo: value must not bypass to HLOut in the write cycle
    task automatic immStimulus(input logic hi_sel, input logic [31:0] val);
        md_if.immWrite = 1'b1;
        md_if.HIWrite  = hi_sel;
        md_if.A        = val;
        md_if.HIRead   = hi_sel;
        #1 checkOutput("imm_no_bypass", md_if.HLOut, hi_sel ? model_hi : model_lo);
        @(negedge clk);
        md_if.immWrite = 1'b0;
        if (hi_sel) model_hi = val;
        else model_lo = val;
        #1 checkOutput("imm_visible", md_if.HLOut, val);
        checkOutput("imm_other", hi_sel ? md_if.LO : md_if.HI, hi_sel ? model_lo : model_hi);
    endtask

    // Flushed start and flushed immWrite must have no effect
    task automatic flushStimulus();
        md_if.start    = 1'b1;
        md_if.flush    = 1'b1;
        md_if.MDop     = 2'b01;
        md_if.MDsign   = 1'b0;
        md_if.A        = 32'd3;
        md_if.B        = 32'd4;
        @(negedge clk);
        md_if.start    = 1'b0;
        md_if.MDop     = 2'b00;
        checkOutput("flush_busy", md_if.busy, 32'd0);
        md_if.immWrite = 1'b1;
        md_if.HIWrite  = 1'b0;
        @(negedge clk);
        md_if.immWrite = 1'b0;
        md_if.flush    = 1'b0;
        checkOutput("flush_busy2", md_if.busy, 32'd0);
        checkOutput("flush_hi", md_if.HI, model_hi);
        checkOutput("flush_lo", md_if.LO, model_lo);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0] op;
        reset          = 1'b1;
        md_if.start    = 1'b0;
        md_if.MDop     = 2'b00;
        md_if.MDsign   = 1'b0;
        md_if.immWrite = 1'b0;
        md_if.HIWrite  = 1'b0;
        md_if.flush    = 1'b0;
        md_if.A        = 32'd0;
        md_if.B        = 32'd0;
        md_if.HIRead   = 1'b0;
        model_hi       = 32'd0;
        model_lo       = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy", md_if.busy, 32'd0);
        checkOutput("reset_hi", md_if.HI, 32'd0);
        checkOutput("reset_lo", md_if.LO, 32'd0);
        checkOutput("reset_hlout", md_if.HLOut, 32'd0);

        $display("[TB] directed operations");
        applyStimulus(2'b01, 1'b1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        checkOutput("mult_hi_const", md_if.HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", md_if.LO, 32'hFFFF_FFFE);
        applyStimulus(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        checkOutput("multu_hi_const", md_if.HI, 32'h0000_0001);
        applyStimulus(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        checkOutput("div_lo_const", md_if.LO, 32'hFFFF_FFFD);
        checkOutput("div_hi_const", md_if.HI, 32'hFFFF_FFFF);
        immStimulus(1'b1, 32'h1234_5678);
        applyStimulus(2'b10, 1'b0, 32'd7, 32'd0, 0, 0, 0);
        checkOutput("divz_hi_const", md_if.HI, 32'h1234_5678);
        applyStimulus(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        checkOutput("ovf_lo_const", md_if.LO, 32'h8000_0000);
        checkOutput("ovf_hi_const", md_if.HI, 32'h0000_0000);
        applyStimulus(2'b01, 1'b0, 32'd1000, 32'd3000, 0, 1, 0);
        applyStimulus(2'b01, 1'b1, 32'd77, 32'd5, 0, 0, 1);
        applyStimulus(2'b11, 1'b1, 32'd9, 32'd9, 0, 0, 0);
        flushStimulus();
        applyStimulus(2'b01, 1'b1, 32'd123, 32'd456, 1, 0, 0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                immStimulus(1'($urandom_range(0, 1)), $urandom);
            end else begin
                op = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
                applyStimulus(op, 1'($urandom_range(0, 1)), pickVal(), pickVal(),
                              0, ($urandom_range(0, 4) == 0), 0);
            end
        end

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
